// File: rtl/fetch_controller_pkg.sv
// -----------------------------------------------------------------------------
// fetch_controller_pkg
// Shared widths and state encoding for the instruction fetch controller.
//   ADDR_WIDTH    : instruction address width in bits
//   DATA_WIDTH    : instruction word width in bits
//   fetch_state_e : fetch FSM encoding (idle / request outstanding)
// -----------------------------------------------------------------------------
package fetch_controller_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// -----------------------------------------------------------------------------
// fetch_controller_if
// Instruction-memory request/acknowledge bus.
//   req   : fetch request, held until ack
//   addr  : fetch address, stable while req is high
//   ack   : memory acknowledge, rdata valid in the same cycle
//   rdata : fetched instruction word
// Modports: master (fetch controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface fetch_controller_if;
    import fetch_controller_pkg::*;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Owns the program counter, issues one outstanding instruction-memory fetch at
// a time and holds the returned word in a one-entry buffer toward decode.
// Redirects from execute reload the PC and squash any in-flight fetch.
// Ports:
//   clk_i          : clock
//   arst_ni        : asynchronous reset, active low
//   imem           : instruction-memory bus (master modport)
//   redirect_i     : one-cycle redirect pulse
//   redirect_pc_i  : redirect target, sampled with redirect_i
//   instr_valid_o  : buffer holds a valid instruction
//   instr_ready_i  : decode accepts the buffered instruction
//   instr_o        : buffered instruction
//   pc_o           : address the buffered instruction came from
// -----------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_INC   = ADDR_WIDTH'(DATA_WIDTH / 8)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    fetch_controller_if.master    imem,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam logic [0:0] ST_IDLE = FETCH_IDLE;
    localparam logic [0:0] ST_REQ  = FETCH_REQ;

    logic [0:0]            state_q,  state_d;
    logic                  squash_q, squash_d;
    logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  valid_q,  valid_d;
    logic [DATA_WIDTH-1:0] instr_q,  instr_d;
    logic [ADDR_WIDTH-1:0] pco_q,    pco_d;

    logic buf_free;
    logic in_req;
    logic ack_fire;
    logic capture;

    always_comb begin
        buf_free = !valid_q || instr_ready_i;
        in_req   = (state_q == ST_REQ);
        ack_fire = in_req && imem.ack;
        // Squashed or redirect-coincident acks close the handshake but drop data.
        capture  = ack_fire && !squash_q && !redirect_i;

        state_d  = state_q;
        squash_d = squash_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pco_d    = pco_q;

        if (!in_req) begin
            // A redirect empties the buffer, so it also frees it for the next fetch.
            if (buf_free || redirect_i) begin
                state_d = ST_REQ;
            end
        end else if (ack_fire) begin
            if (capture && !instr_ready_i) begin
                state_d = ST_IDLE;
            end
        end

        // An unacked request cannot be withdrawn, so remember to drop its data.
        if (redirect_i && in_req && !imem.ack) begin
            squash_d = 1'b1;
        end else if (ack_fire) begin
            squash_d = 1'b0;
        end

        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (capture) begin
            pc_d = pc_q + PC_INC;
        end

        // Address is frozen while a handshake is open; otherwise it follows the PC.
        if (!(in_req && !imem.ack)) begin
            addr_d = pc_d;
        end

        if (redirect_i) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            instr_d = imem.rdata;
            pco_d   = pc_q;
        end else if (valid_q && instr_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= ST_IDLE;
            squash_q <= 1'b0;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pco_q    <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pco_q    <= pco_d;
        end
    end

    assign imem.req      = in_req;
    assign imem.addr     = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pco_q;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller. A memory responder acks requests after a
// programmable delay with data derived from the address; a monitor pops the
// expected (pc, instr) pair from a scoreboard queue on every decode handshake.
// -----------------------------------------------------------------------------
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam logic [31:0] K = 32'hC0DE_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    fetch_controller_if bus();

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .imem          (bus),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ K;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Memory responder: ack after ack_delay waiting cycles, data = addr ^ K.
    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;
        forever begin
            @(posedge clk_i);
            #2;
            bus.ack = 1'b0;
            if (arst_ni && bus.req) begin
                if (wait_cnt >= ack_delay) begin
                    bus.ack   = 1'b1;
                    bus.rdata = bus.addr ^ K;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every decode handshake must match the next expected word.
    always @(negedge clk_i) begin
        exp_t e;
        if (arst_ni && instr_valid_o && instr_ready_i) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got pc 0x%08h, want no handshake", pc_o);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_instr", instr_o, e.instr);
            end
        end
    end

    initial begin
        arst_ni       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b1;
        #1 arst_ni = 1'b0;
        step();
        step();
        chk("rst_req",   32'(bus.req), 32'd0);
        chk("rst_addr",  bus.addr, 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc",    pc_o, 32'h0);

        // Streaming from reset, then a 3-cycle ack delay on address 0x4.
        push(32'h0);
        push(32'h4);
        arst_ni = 1'b1;
        step();                                     // t1
        chk("t1_req",   32'(bus.req), 32'd1);
        chk("t1_addr",  bus.addr, 32'h0);
        chk("t1_valid", 32'(instr_valid_o), 32'd0);
        step();                                     // t2
        ack_delay = 3;
        chk("t2_valid", 32'(instr_valid_o), 32'd1);
        chk("t2_addr",  bus.addr, 32'h4);
        for (int i = 0; i < 3; i++) begin           // t3..t5
            step();
            chk("hold_req",  32'(bus.req), 32'd1);
            chk("hold_addr", bus.addr, 32'h4);
        end

        // Backpressure: buffer full, decode stalled for 4 cycles.
        ack_delay     = 0;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin           // t6..t9
            step();
            chk("bp_req",   32'(bus.req), 32'd0);
            chk("bp_valid", 32'(instr_valid_o), 32'd1);
            chk("bp_pc",    pc_o, 32'h4);
            chk("bp_instr", instr_o, 32'h4 ^ K);
        end
        step();                                     // t10
        instr_ready_i = 1'b1;
        ack_delay     = 2;
        chk("bp_rel_req", 32'(bus.req), 32'd0);

        // Redirect while the fetch to 0x8 is outstanding.
        step();                                     // t11
        chk("rd_req",  32'(bus.req), 32'd1);
        chk("rd_addr", bus.addr, 32'h8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();                                     // t12
        redirect_i = 1'b0;
        chk("sq_addr1", bus.addr, 32'h8);
        step();                                     // t13
        ack_delay = 0;
        chk("sq_addr2", bus.addr, 32'h8);
        step();                                     // t14
        chk("sq_valid",  32'(instr_valid_o), 32'd0);
        chk("sq_newadr", bus.addr, 32'h100);

        // Redirect coincident with an ack while the buffer is full and stalled.
        step();                                     // t15
        chk("co_valid", 32'(instr_valid_o), 32'd1);
        chk("co_pc",    pc_o, 32'h100);
        instr_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();                                     // t16
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        push(32'h200);
        chk("co_flush", 32'(instr_valid_o), 32'd0);
        chk("co_addr",  bus.addr, 32'h200);

        // Address wrap from the top aligned address.
        step();                                     // t17
        chk("wr_valid", 32'(instr_valid_o), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();                                     // t18
        redirect_i = 1'b0;
        chk("wr_top",   bus.addr, 32'hFFFF_FFFC);
        chk("wr_valid0", 32'(instr_valid_o), 32'd0);
        step();                                     // t19
        instr_ready_i = 1'b0;
        ack_delay     = 3;
        chk("wr_addr0", bus.addr, 32'h0);
        chk("wr_pc",    pc_o, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of an outstanding request.
        step();                                     // t20
        chk("mr_req",   32'(bus.req), 32'd1);
        chk("mr_valid", 32'(instr_valid_o), 32'd1);
        #2 arst_ni = 1'b0;
        #1;
        chk("ar_req",   32'(bus.req), 32'd0);
        chk("ar_valid", 32'(instr_valid_o), 32'd0);
        chk("ar_instr", instr_o, 32'h0);
        chk("ar_pc",    pc_o, 32'h0);
        chk("ar_addr",  bus.addr, 32'h0);
        step();
        step();
        arst_ni = 1'b1;
        step();
        chk("re_req",  32'(bus.req), 32'd1);
        chk("re_addr", bus.addr, 32'h0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
